// File: rtl/interp_row_sequencer.sv
// Row sequencer for the shared 8-tap interpolation window: loads pixels, pads both
// row edges by replication and emits one {original, A, B, C} sample group per pixel.
module interp_row_sequencer #(
  parameter int NORM_SHIFT = 6
) (
  input  logic            clock,
  input  logic            reset_L,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_pixel,
  input  logic            in_last,
  output logic [7:0][7:0] data_buffer,
  input  logic [31:0]     a_value,
  input  logic [31:0]     b_value,
  input  logic [31:0]     c_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_pixel,
  output logic [1:0]      out_phase,
  output logic            out_last,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits for ready, and ready is decoded from state only.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  localparam logic signed [31:0] ROUND = 32'sd1 <<< (NORM_SHIFT - 1);

  state_t          r_state;
  logic [7:0][7:0] r_buf;
  logic [2:0]      r_sc;
  logic            r_last_seen;
  logic [2:0]      r_flush_left;
  logic [1:0]      r_phase;

  logic            w_in_hs;
  logic            w_out_hs;
  logic [2:0]      w_sc_inc;
  logic            w_row_done;

  assign in_ready    = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign out_valid   = (r_state == ST_EMIT);
  assign busy        = (r_state != ST_IDLE);
  assign dbg_state   = r_state;
  assign data_buffer = r_buf;
  assign out_phase   = r_phase;

  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = out_valid && out_ready;
  assign w_sc_inc   = (r_sc >= 3'd4) ? 3'd4 : r_sc + 3'd1;
  assign w_row_done = r_last_seen && (r_flush_left == 3'd0);
  assign out_last   = out_valid && (r_phase == 2'd3) && w_row_done;

  function automatic logic [7:0] norm(input logic [31:0] v);
    logic signed [31:0] s;
    s = ($signed(v) + ROUND) >>> NORM_SHIFT;
    if (s < 32'sd0)
      norm = 8'd0;
    else if (s > 32'sd255)
      norm = 8'd255;
    else
      norm = s[7:0];
  endfunction

  always_comb begin
    out_pixel = 8'd0;
    if (r_state == ST_EMIT) begin
      case (r_phase)
        2'd0:    out_pixel = r_buf[4];
        2'd1:    out_pixel = norm(a_value);
        2'd2:    out_pixel = norm(b_value);
        default: out_pixel = norm(c_value);
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= ST_IDLE;
      r_buf        <= '0;
      r_sc         <= 3'd0;
      r_last_seen  <= 1'b0;
      r_flush_left <= 3'd0;
      r_phase      <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_hs) begin
            // Left-edge replication: the first pixel fills the whole window.
            r_buf <= {8{in_pixel}};
            r_sc  <= 3'd0;
            if (in_last) begin
              r_last_seen  <= 1'b1;
              r_flush_left <= 3'd4;
              r_state      <= ST_FLUSH;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_in_hs) begin
            r_buf <= {r_buf[6:0], in_pixel};
            r_sc  <= w_sc_inc;
            if (in_last) begin
              r_last_seen  <= 1'b1;
              r_flush_left <= 3'd4;
            end
            if (w_sc_inc >= 3'd4)
              r_state <= ST_EMIT;
            else if (in_last || r_last_seen)
              r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Right-edge replication: the newest pixel is repeated past the row end.
          r_buf <= {r_buf[6:0], r_buf[0]};
          r_sc  <= w_sc_inc;
          if (r_flush_left != 3'd0)
            r_flush_left <= r_flush_left - 3'd1;
          if (w_sc_inc >= 3'd4)
            r_state <= ST_EMIT;
        end
        default: begin
          if (w_out_hs) begin
            if (r_phase == 2'd3) begin
              r_phase <= 2'd0;
              if (w_row_done) begin
                r_last_seen <= 1'b0;
                r_state     <= ST_IDLE;
              end else if (r_last_seen) begin
                r_state <= ST_FLUSH;
              end else begin
                r_state <= ST_LOAD;
              end
            end else begin
              r_phase <= r_phase + 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interp_row_sequencer.sv
// Bench for interp_row_sequencer: attached reference filters, table of row vectors
// with a sample scoreboard, plus hand sequences for flush timing, rounding and reset.
module tb_interp_row_sequencer;

  logic            clock = 1'b0;
  logic            reset_L;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_pixel;
  logic            in_last;
  logic [7:0][7:0] data_buffer;
  logic [31:0]     a_value;
  logic [31:0]     b_value;
  logic [31:0]     c_value;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_pixel;
  logic [1:0]      out_phase;
  logic            out_last;
  logic            busy;
  logic [1:0]      dbg_state;

  logic            force_a = 1'b0;
  logic [31:0]     force_a_val = '0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       exp_last_q[$];

  // Filter taps: A and C sum to 72, B to 56 (unity is 64 with a shift of 6).
  int coef_a[8] = '{-2, 6, -12, 60, 20, -6, 4, 2};
  int coef_b[8] = '{-2, 4, -8, 34, 34, -8, 4, -2};
  int coef_c[8] = '{2, 4, -6, 20, 60, -12, 6, -2};

  typedef struct {
    int               n1;
    int               n2;
    logic [15:0][7:0] pix;
    bit               bp;
    bit               has_pat;
    logic [3:0][7:0]  pat;
  } row_vec_t;

  typedef struct {
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       in_last;
    logic       out_ready;
    logic       e_in_ready;
    logic       e_out_valid;
    logic [7:0] e_pixel;
    logic [1:0] e_phase;
    logic       e_last;
    logic       e_busy;
  } cyc_vec_t;

  row_vec_t rows[7];
  cyc_vec_t seq[10];

  interp_row_sequencer #(.NORM_SHIFT(6)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .in_last     (in_last),
    .data_buffer (data_buffer),
    .a_value     (a_value),
    .b_value     (b_value),
    .c_value     (c_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .out_phase   (out_phase),
    .out_last    (out_last),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- attached filter units ----------------
  function automatic int filt(input logic [7:0][7:0] w, input int sel);
    int s;
    s = 0;
    for (int j = 0; j < 8; j++) begin
      case (sel)
        0:       s += coef_a[j] * int'(w[j]);
        1:       s += coef_b[j] * int'(w[j]);
        default: s += coef_c[j] * int'(w[j]);
      endcase
    end
    return s;
  endfunction

  always_comb begin
    a_value = force_a ? force_a_val : 32'(filt(data_buffer, 0));
    b_value = 32'(filt(data_buffer, 1));
    c_value = 32'(filt(data_buffer, 2));
  end

  // ---------------- model ----------------
  function automatic logic [7:0] exp_norm(input int v);
    int r;
    r = v + 32;
    if (r < 0) return 8'd0;
    if (r / 64 > 255) return 8'd255;
    return 8'(r / 64);
  endfunction

  function automatic logic [7:0] model_sample(input logic [15:0][7:0] p, input int base,
                                              input int n, input int k, input int ph);
    logic [7:0][7:0] w;
    int idx;
    for (int j = 0; j < 8; j++) begin
      idx = k + 4 - j;
      if (idx < 0) idx = 0;
      if (idx > n - 1) idx = n - 1;
      w[j] = p[base + idx];
    end
    if (ph == 0) return w[4];
    return exp_norm(filt(w, ph - 1));
  endfunction

  task automatic push_row(input row_vec_t r, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      for (int ph = 0; ph < 4; ph++) begin
        exp_q.push_back(r.has_pat ? r.pat[ph] : model_sample(r.pix, base, n, k, ph));
        exp_last_q.push_back((k == n - 1) && (ph == 3));
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_pixels(input logic [15:0][7:0] p, input int base, input int n,
                              input bit mark_last);
    int w_cnt;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_pixel = p[base + i];
      in_last  = mark_last && (i == n - 1);
      w_cnt    = 0;
      while (!in_ready && w_cnt < 200) begin
        @(negedge clock);
        w_cnt++;
      end
      if (w_cnt >= 200) begin
        check("in_ready_wait", 64'(in_ready), 64'd1);
        return;
      end
      @(posedge clock);
    end
  endtask

  task automatic sink(input int total, input bit bp);
    int got, cyc;
    bit stalled;
    logic [7:0] h_pix;
    logic [7:0][7:0] h_buf;
    logic h_last;
    got = 0; cyc = 0; stalled = 0;
    h_pix = '0; h_buf = '0; h_last = 1'b0;
    while (got < total && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_pixel", 64'(out_pixel), 64'(h_pix));
        check("stall_last", 64'(out_last), 64'(h_last));
        check("stall_buffer", 64'(data_buffer), 64'(h_buf));
      end
      stalled = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_sample actual=%0d required=none", out_pixel);
          return;
        end
        check("sample_pixel", 64'(out_pixel), 64'(exp_q[0]));
        check("sample_phase", 64'(out_phase), 64'(got % 4));
        check("sample_last", 64'(out_last), 64'(exp_last_q[0]));
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
          got++;
        end else begin
          stalled = 1;
          h_pix   = out_pixel;
          h_buf   = data_buffer;
          h_last  = out_last;
        end
      end else begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    check("sample_count", 64'(got), 64'(total));
  endtask

  task automatic run_rows(input row_vec_t r);
    push_row(r, 0, r.n1);
    if (r.n2 > 0) push_row(r, r.n1, r.n2);
    fork
      begin
        drive_pixels(r.pix, 0, r.n1, 1'b1);
        if (r.n2 > 0) drive_pixels(r.pix, r.n1, r.n2, 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      sink(4 * (r.n1 + r.n2), r.bp);
    join
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("no_extra_valid", 64'(out_valid), 64'd0);
    check("idle_after_row", 64'(busy), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    exp_last_q.delete();
  endtask

  task automatic set_row(input int i, input int n1, input int n2, input bit bp,
                         input bit has_pat, input logic [3:0][7:0] pat,
                         input logic [15:0][7:0] pix);
    rows[i].n1 = n1; rows[i].n2 = n2; rows[i].bp = bp;
    rows[i].has_pat = has_pat; rows[i].pat = pat; rows[i].pix = pix;
  endtask

  task automatic set_cyc(input int i, input logic v, input logic [7:0] p, input logic l,
                         input logic ordy, input logic eir, input logic eov,
                         input logic [7:0] epix, input logic [1:0] eph,
                         input logic elast, input logic ebusy);
    seq[i].in_valid = v; seq[i].in_pixel = p; seq[i].in_last = l; seq[i].out_ready = ordy;
    seq[i].e_in_ready = eir; seq[i].e_out_valid = eov; seq[i].e_pixel = epix;
    seq[i].e_phase = eph; seq[i].e_last = elast; seq[i].e_busy = ebusy;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0][7:0] rst_pix;
    int w_cnt;

    // Row vectors; pat is {C, B, A, original} for constant rows.
    set_row(0, 8, 0, 1'b0, 1'b1, {8'd113, 8'd88, 8'd113, 8'd100}, {16{8'd100}});
    set_row(1, 4, 0, 1'b0, 1'b1, {8'd255, 8'd219, 8'd255, 8'd250}, {16{8'd250}});
    set_row(2, 5, 0, 1'b1, 1'b0, '0, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10});
    set_row(3, 3, 4, 1'b0, 1'b0, '0,
            {8'd35, 8'd25, 8'd15, 8'd5, 8'd160, 8'd180, 8'd200});
    set_row(4, 6, 0, 1'b1, 1'b0, '0, {8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0});
    set_row(5, 2, 0, 1'b0, 1'b0, '0, {8'd90, 8'd30});
    set_row(6, 3, 0, 1'b0, 1'b0, '0, {8'd56, 8'd34, 8'd12});

    // Single-pixel row, per cycle: inputs held high during FLUSH/EMIT must be ignored.
    set_cyc(0, 1, 8'd7,  1, 1, 1, 0, 8'd0, 2'd0, 0, 0);
    set_cyc(1, 1, 8'd99, 1, 1, 0, 0, 8'd0, 2'd0, 0, 1);
    set_cyc(2, 1, 8'd99, 1, 1, 0, 0, 8'd0, 2'd0, 0, 1);
    set_cyc(3, 1, 8'd99, 1, 1, 0, 0, 8'd0, 2'd0, 0, 1);
    set_cyc(4, 1, 8'd99, 1, 1, 0, 0, 8'd0, 2'd0, 0, 1);
    set_cyc(5, 1, 8'd99, 1, 1, 0, 1, 8'd7, 2'd0, 0, 1);
    set_cyc(6, 1, 8'd99, 1, 1, 0, 1, 8'd8, 2'd1, 0, 1);
    set_cyc(7, 1, 8'd99, 1, 1, 0, 1, 8'd6, 2'd2, 0, 1);
    set_cyc(8, 0, 8'd0,  0, 1, 0, 1, 8'd8, 2'd3, 1, 1);
    set_cyc(9, 0, 8'd0,  0, 1, 1, 0, 8'd0, 2'd0, 0, 0);

    // Clock / reset
    reset_L = 1'b0; in_valid = 1'b0; in_pixel = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pixel", 64'(out_pixel), 64'd0);
    check("rst_out_phase", 64'(out_phase), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_buffer", 64'(data_buffer), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset_L = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("seq_in_ready", 64'(in_ready), 64'(seq[i].e_in_ready));
      check("seq_out_valid", 64'(out_valid), 64'(seq[i].e_out_valid));
      check("seq_out_pixel", 64'(out_pixel), 64'(seq[i].e_pixel));
      check("seq_out_phase", 64'(out_phase), 64'(seq[i].e_phase));
      check("seq_out_last", 64'(out_last), 64'(seq[i].e_last));
      check("seq_busy", 64'(busy), 64'(seq[i].e_busy));
      in_valid  = seq[i].in_valid;
      in_pixel  = seq[i].in_pixel;
      in_last   = seq[i].in_last;
      out_ready = seq[i].out_ready;
    end

    for (int i = 0; i < 6; i++) run_rows(rows[i]);

    // Rounding / clamp with a forced A result while stalled in phase 1.
    out_ready = 1'b0;
    drive_pixels({16{8'd40}}, 0, 1, 1'b1);
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
    w_cnt = 0;
    while (!out_valid && w_cnt < 20) begin
      @(negedge clock);
      w_cnt++;
    end
    check("force_reach_emit", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("force_phase", 64'(out_phase), 64'd1);
    force_a = 1'b1;
    force_a_val = -32'sd100; #1;
    check("round_neg100", 64'(out_pixel), 64'd0);
    force_a_val = 32'sd95; #1;
    check("round_95", 64'(out_pixel), 64'd1);
    force_a_val = 32'sd96; #1;
    check("round_96", 64'(out_pixel), 64'd2);
    force_a = 1'b0; #1;
    check("filter_a_40", 64'(out_pixel), 64'd45);
    out_ready = 1'b1;
    w_cnt = 0;
    while (busy && w_cnt < 20) begin
      @(negedge clock);
      w_cnt++;
    end
    check("force_row_done", 64'(busy), 64'd0);

    // Mid-row reset during EMIT phase 2.
    rst_pix = {8'd100, 8'd90, 8'd80, 8'd70, 8'd60};
    out_ready = 1'b0;
    drive_pixels(rst_pix, 0, 5, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    check("mid_emit_valid", 64'(out_valid), 64'd1);
    check("mid_emit_orig", 64'(out_pixel), 64'd60);
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    out_ready = 1'b0;
    check("mid_emit_phase2", 64'(out_phase), 64'd2);
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pixel", 64'(out_pixel), 64'd0);
    check("mid_rst_phase", 64'(out_phase), 64'd0);
    check("mid_rst_last", 64'(out_last), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_buffer", 64'(data_buffer), 64'd0);
    @(negedge clock);
    reset_L = 1'b1;
    out_ready = 1'b1;
    run_rows(rows[6]);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
